// File: rtl/loba_acc_pkg.sv
// Shared types and defaults for the LOBA product accumulator stage.
// Build option LOBA_ACC_SAT_EN selects saturating accumulation (see loba_sat_add).
package loba_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned N_DEF     = 16;
    localparam int unsigned LEN_DEF   = 4;
    localparam int unsigned ACC_W_DEF = 36;

    // Width able to hold a count from 0 to len inclusive.
    function automatic int unsigned cnt_w(input int unsigned len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/loba_sat_add.sv
// Combinational ACC_W-bit unsigned adder with carry-out.
// With LOBA_ACC_SAT_EN defined, a carry clamps the sum to all-ones; otherwise it wraps.
module loba_sat_add
    import loba_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[ACC_W];

`ifdef LOBA_ACC_SAT_EN
    // Once clamped, any further non-zero addend carries again, so the clamp persists.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/loba_acc_stage.sv
// Groups LEN multiplier products into a sum, presented on a held valid/ready output.
// Build option LOBA_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module loba_acc_stage
    import loba_acc_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LEN   = LEN_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    localparam int unsigned CNT_W = cnt_w(LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_p,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_cnt,
    output logic               out_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_ovf;

    logic               w_beat;
    logic               w_close;
    logic [ACC_W-1:0]   w_p_ext;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_carry;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;

    assign w_p_ext = ACC_W'(in_p);

    loba_sat_add #(.ACC_W(ACC_W)) u_add (
        .i_a     (r_acc),
        .i_b     (w_p_ext),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    assign w_beat    = in_valid & in_ready;
    assign w_acc_nxt = w_beat ? w_add_sum : r_acc;
    assign w_cnt_nxt = w_beat ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_ovf_nxt = r_ovf | (w_beat & w_add_carry);

    // An idle flush (nothing accumulated, no beat) must not emit an empty group.
    assign w_close = (r_state == ACCUM) &
                     ((w_beat & (r_cnt == CNT_W'(LEN - 1))) |
                      (flush & ((r_cnt != '0) | w_beat)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the case leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_close)   w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Decoded from state alone, so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready = (r_state == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_close) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_nxt;
            r_out_cnt   <= w_cnt_nxt;
            r_out_ovf   <= w_ovf_nxt;
        end else if (r_state == HOLD && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_loba_acc_stage.sv
// Directed bench for loba_acc_stage: default ACC_W=36 instance plus an ACC_W=32 instance for overflow.
module tb_loba_acc_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_p;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [35:0] out_sum;
    logic [2:0]  out_cnt;
    logic        out_ovf;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_sum32;
    logic [2:0]  out_cnt32;
    logic        out_ovf32;

    int n_tests = 0;
    int n_fail  = 0;

    loba_acc_stage #(.N(16), .LEN(4), .ACC_W(36)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    loba_acc_stage #(.N(16), .LEN(4), .ACC_W(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .in_p      (in_p),
        .flush     (flush),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_sum   (out_sum32),
        .out_cnt   (out_cnt32),
        .out_ovf   (out_ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p);
        in_valid = 1'b1;
        in_p     = p;
        tick();
        in_valid = 1'b0;
        in_p     = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_p = '0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_sum !== 36'h0) begin n_fail++; $display("FAIL reset_sum: got %0h expected 0", out_sum); end
        n_tests++; if (out_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", out_cnt); end
        n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", out_ovf); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_group();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(32'h0001_0000);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL group_early_valid: beat %0d got %0b expected 0", i, out_valid); end
        end
        beat(32'h0001_0000);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL group_valid: got %0b expected 1", out_valid); end
        n_tests++; if (out_sum !== 36'h4_0000) begin n_fail++; $display("FAIL group_sum: got %0h expected 40000", out_sum); end
        n_tests++; if (out_cnt !== 3'd4) begin n_fail++; $display("FAIL group_cnt: got %0d expected 4", out_cnt); end
        n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL group_ovf: got %0b expected 0", out_ovf); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL group_in_ready_hold: got %0b expected 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL group_single_cycle: got %0b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL group_in_ready_back: got %0b expected 1", in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h0001_0000);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %0b expected 1", i, out_valid); end
            n_tests++; if (out_sum !== 36'h4_0000) begin n_fail++; $display("FAIL bp_sum: cycle %0d got %0h expected 40000", i, out_sum); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %0b expected 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: got %0b expected 0", in_ready); end
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        beat(32'h10);
        beat(32'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %0b expected 1", out_valid); end
        n_tests++; if (out_sum !== 36'h30) begin n_fail++; $display("FAIL flush_sum: got %0h expected 30", out_sum); end
        n_tests++; if (out_cnt !== 3'd2) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 2", out_cnt); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %0b expected 0", out_valid); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_late: got %0b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_flush_with_beat();
        beat(32'h7);
        in_valid = 1'b1;
        in_p     = 32'h5;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flushbeat_valid: got %0b expected 1", out_valid); end
        n_tests++; if (out_sum !== 36'hC) begin n_fail++; $display("FAIL flushbeat_sum: got %0h expected c", out_sum); end
        n_tests++; if (out_cnt !== 3'd2) begin n_fail++; $display("FAIL flushbeat_cnt: got %0d expected 2", out_cnt); end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) beat(32'hFFFF_FFFF);
        n_tests++; if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL ovf32_valid: got %0b expected 1", out_valid32); end
`ifdef LOBA_ACC_SAT_EN
        n_tests++; if (out_sum32 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf32_sum: got %0h expected ffffffff", out_sum32); end
`else
        n_tests++; if (out_sum32 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ovf32_sum: got %0h expected fffffffc", out_sum32); end
`endif
        n_tests++; if (out_ovf32 !== 1'b1) begin n_fail++; $display("FAIL ovf32_flag: got %0b expected 1", out_ovf32); end
        n_tests++; if (out_cnt32 !== 3'd4) begin n_fail++; $display("FAIL ovf32_cnt: got %0d expected 4", out_cnt32); end
        n_tests++; if (out_sum !== 36'h3_FFFF_FFFC) begin n_fail++; $display("FAIL ovf36_sum: got %0h expected 3fffffffc", out_sum); end
        n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf36_flag: got %0b expected 0", out_ovf); end
        tick();
        // Sticky flag must not leak into the next group.
        for (int i = 0; i < 4; i++) beat(32'h1);
        n_tests++; if (out_ovf32 !== 1'b0) begin n_fail++; $display("FAIL ovf32_cleared: got %0b expected 0", out_ovf32); end
        n_tests++; if (out_sum32 !== 32'h4) begin n_fail++; $display("FAIL ovf32_next_sum: got %0h expected 4", out_sum32); end
        tick();
    endtask

    task automatic test_reset_mid();
        beat(32'h1);
        beat(32'h1);
        rst_n = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_sum !== 36'h0) begin n_fail++; $display("FAIL rstmid_sum: got %0h expected 0", out_sum); end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) beat(32'h1);
        n_tests++; if (out_sum !== 36'h4) begin n_fail++; $display("FAIL rstmid_after_sum: got %0h expected 4", out_sum); end
        n_tests++; if (out_cnt !== 3'd4) begin n_fail++; $display("FAIL rstmid_after_cnt: got %0d expected 4", out_cnt); end
        tick();
        // Reset while a finished group is held discards it.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h9);
        rst_n = 1'b0;
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_sum !== 36'h0) begin n_fail++; $display("FAIL rsthold_sum: got %0h expected 0", out_sum); end
        n_tests++; if (out_cnt !== 3'd0) begin n_fail++; $display("FAIL rsthold_cnt: got %0d expected 0", out_cnt); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rsthold_in_ready: got %0b expected 1", in_ready); end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_group();
        test_backpressure();
        test_flush();
        test_flush_with_beat();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
